// File: rtl/trigger_chain_tap_capture.sv
// Per-channel delay-matched tap selector (raw/LPF/biquad) feeding AGC, plus a triggered
// WB-readable capture buffer. Optional TSTAMP clock counter: define TRIG_CAP_TIMESTAMP_EN.
module trigger_chain_tap_capture #(
    parameter int unsigned NCHAN     = 8,
    parameter int unsigned NSAMP     = 8,
    parameter int unsigned NBITS     = 12,
    parameter int unsigned LAT_LPF   = 3,
    parameter int unsigned LAT_BQ    = 7,
    parameter int unsigned CAP_DEPTH = 256,
    parameter int unsigned WB_ADR_W  = 22
) (
    input  logic                         aclk,
    input  logic                         reset_i,
    input  logic                         wb_cyc_i,
    input  logic                         wb_stb_i,
    input  logic                         wb_we_i,
    input  logic [WB_ADR_W-1:0]          wb_adr_i,
    input  logic [31:0]                  wb_dat_i,
    input  logic [3:0]                   wb_sel_i,
    output logic [31:0]                  wb_dat_o,
    output logic                         wb_ack_o,
    input  logic [NCHAN*NSAMP*NBITS-1:0] raw_i,
    input  logic [NCHAN*NSAMP*NBITS-1:0] lpf_i,
    input  logic [NCHAN*NSAMP*NBITS-1:0] bq_i,
    input  logic                         trig_i,
    output logic [NCHAN*NSAMP*NBITS-1:0] dat_o,
    output logic                         cap_done_o
);
    localparam int unsigned EW    = NSAMP * NBITS;
    localparam int unsigned BW    = NCHAN * EW;
    localparam int unsigned TW    = 2 * NCHAN;
    localparam int unsigned LAT_D = LAT_BQ - LAT_LPF;
    localparam int unsigned AW    = $clog2(CAP_DEPTH);
    localparam int unsigned CW    = AW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [3:0]      capch, capch_l, cap_ch_c;
    logic [1:0]      captap, captap_l, cap_tap_c;
    logic [TW-1:0]   tapsel;
    logic [BW-1:0]   raw_al, lpf_al, dat_c;
    logic [EW-1:0]   cap_src_c;
    logic [EW-1:0]   mem [CAP_DEPTH];
    logic [95:0]     ent_c;
    logic [31:0]     rdata_c, tstamp_c;
    logic            req_c, wr_c, arm_c, abort_c, trig_go_c, cap_we_c, buf_hit_c;
    logic [AW-1:0]   widx_c;
    logic            unused_c;

    assign unused_c = ^{wb_sel_i, wb_dat_i};

    // Raw tap delayed by the full biquad latency
    generate
        if (LAT_BQ == 0) begin : g_raw_pass
            assign raw_al = raw_i;
        end else begin : g_raw_dly
            logic [BW-1:0] pipe [LAT_BQ];
            always_ff @(posedge aclk) begin
                if (reset_i) begin
                    for (int i = 0; i < int'(LAT_BQ); i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= raw_i;
                    for (int i = 1; i < int'(LAT_BQ); i++) pipe[i] <= pipe[i-1];
                end
            end
            assign raw_al = pipe[LAT_BQ-1];
        end
    endgenerate

    // LPF tap delayed by the remaining biquad-over-LPF latency
    generate
        if (LAT_D == 0) begin : g_lpf_pass
            assign lpf_al = lpf_i;
        end else begin : g_lpf_dly
            logic [BW-1:0] pipe [LAT_D];
            always_ff @(posedge aclk) begin
                if (reset_i) begin
                    for (int i = 0; i < int'(LAT_D); i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= lpf_i;
                    for (int i = 1; i < int'(LAT_D); i++) pipe[i] <= pipe[i-1];
                end
            end
            assign lpf_al = pipe[LAT_D-1];
        end
    endgenerate

    always_comb begin
        dat_c = '0;
        for (int c = 0; c < int'(NCHAN); c++) begin
            case (tapsel[2*c +: 2])
                2'd0:    dat_c[c*EW +: EW] = raw_al[c*EW +: EW];
                2'd1:    dat_c[c*EW +: EW] = lpf_al[c*EW +: EW];
                2'd2:    dat_c[c*EW +: EW] = bq_i[c*EW +: EW];
                default: dat_c[c*EW +: EW] = '0;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (reset_i) dat_o <= '0;
        else         dat_o <= dat_c;
    end

    // Trigger-cycle entry uses live CAPCH/CAPTAP; later entries use the latched copies
    always_comb begin
        cap_ch_c  = (state == CAPTURE) ? capch_l  : capch;
        cap_tap_c = (state == CAPTURE) ? captap_l : captap;
        cap_src_c = '0;
        for (int c = 0; c < int'(NCHAN); c++) begin
            if (4'(c) == cap_ch_c) begin
                case (cap_tap_c)
                    2'd0:    cap_src_c = raw_al[c*EW +: EW];
                    2'd1:    cap_src_c = lpf_al[c*EW +: EW];
                    2'd2:    cap_src_c = bq_i[c*EW +: EW];
                    default: cap_src_c = '0;
                endcase
            end
        end
    end

    assign req_c     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr_c      = req_c & wb_we_i;
    assign arm_c     = wr_c && (wb_adr_i == WB_ADR_W'(0)) && wb_dat_i[0];
    assign abort_c   = wr_c && (wb_adr_i == WB_ADR_W'(0)) && wb_dat_i[1];
    assign trig_go_c = (state == ARMED) && trig_i && !abort_c;
    assign cap_we_c  = !reset_i && !abort_c && (trig_go_c || (state == CAPTURE));
    assign widx_c    = (state == CAPTURE) ? count[AW-1:0] : '0;
    assign buf_hit_c = (wb_adr_i >> (AW + 2)) == WB_ADR_W'(1);

    always_ff @(posedge aclk) begin
        if (cap_we_c) mem[widx_c] <= cap_src_c;
    end

    always_ff @(posedge aclk) begin
        if (reset_i) begin
            state      <= IDLE;
            count      <= '0;
            capch_l    <= '0;
            captap_l   <= '0;
            cap_done_o <= 1'b0;
        end else if (abort_c) begin
            state      <= IDLE;
            cap_done_o <= 1'b0;
        end else begin
            case (state)
                IDLE: if (arm_c) state <= ARMED;
                ARMED: begin
                    if (trig_i) begin
                        state    <= CAPTURE;
                        count    <= CW'(1);
                        capch_l  <= capch;
                        captap_l <= captap;
                    end
                end
                CAPTURE: begin
                    count <= count + CW'(1);
                    if (count == CW'(CAP_DEPTH - 1)) begin
                        state      <= DONE;
                        cap_done_o <= 1'b1;
                    end
                end
                DONE: begin
                    if (arm_c) begin
                        state      <= ARMED;
                        cap_done_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (reset_i) begin
            capch  <= '0;
            captap <= '0;
            tapsel <= {NCHAN{2'b10}};
        end else if (wr_c) begin
            if (wb_adr_i == WB_ADR_W'(2)) capch  <= wb_dat_i[3:0];
            if (wb_adr_i == WB_ADR_W'(3)) tapsel <= wb_dat_i[TW-1:0];
            if (wb_adr_i == WB_ADR_W'(4)) captap <= wb_dat_i[1:0];
        end
    end

`ifdef TRIG_CAP_TIMESTAMP_EN
    logic [31:0] clk_cnt;
    logic [31:0] tstamp;
    always_ff @(posedge aclk) begin
        if (reset_i) begin
            clk_cnt <= '0;
            tstamp  <= '0;
        end else begin
            clk_cnt <= clk_cnt + 32'd1;
            if (trig_go_c) tstamp <= clk_cnt;
        end
    end
    assign tstamp_c = tstamp;
`else
    assign tstamp_c = '0;
`endif

    // Read mux: buffer window is blanked while a capture is in progress
    always_comb begin
        rdata_c = '0;
        ent_c   = 96'(mem[wb_adr_i[AW+1:2]]);
        if (buf_hit_c) begin
            if (state != CAPTURE) begin
                case (wb_adr_i[1:0])
                    2'd0:    rdata_c = ent_c[31:0];
                    2'd1:    rdata_c = ent_c[63:32];
                    2'd2:    rdata_c = ent_c[95:64];
                    default: rdata_c = '0;
                endcase
            end
        end else begin
            case (wb_adr_i)
                WB_ADR_W'(1): rdata_c = {16'(count), 14'd0, state};
                WB_ADR_W'(2): rdata_c = 32'(capch);
                WB_ADR_W'(3): rdata_c = 32'(tapsel);
                WB_ADR_W'(4): rdata_c = 32'(captap);
                WB_ADR_W'(5): rdata_c = tstamp_c;
                default:      rdata_c = '0;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (reset_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= req_c;
            if (req_c && !wb_we_i) wb_dat_o <= rdata_c;
        end
    end

endmodule

// File: tb/tb_trigger_chain_tap_capture.sv
// Bench for trigger_chain_tap_capture: directed tap-alignment, capture, abort and reset
// scenarios; WB read data is checked by a scoreboard monitor on wb_ack_o.
module tb_trigger_chain_tap_capture;
    localparam int unsigned BW = 768;

    logic          aclk = 1'b0;
    logic          reset_i = 1'b1;
    logic          wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
    logic [21:0]   wb_adr_i = '0;
    logic [31:0]   wb_dat_i = '0;
    logic [3:0]    wb_sel_i = 4'hF;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_o;
    logic [BW-1:0] raw_i = '0, lpf_i = '0, bq_i = '0, dat_o;
    logic          trig_i = 1'b0;
    logic          cap_done_o;

    logic [BW-1:0] raw_set = '0;
    logic [BW-1:0] hist [7] = '{default: '0};
    logic [BW-1:0] imp;
    bit            ramp_en = 1'b0;
    int            rc = 0, rc_trig = 0, cyc_n = 0, rel_n = 0;
    int            n_chk = 0, n_fail = 0;
    logic [31:0]   exp_q [$];
    string         name_q [$];
    logic [31:0]   mon_e;
    string         mon_nm;

    trigger_chain_tap_capture #(
        .NCHAN(8), .NSAMP(8), .NBITS(12), .LAT_LPF(3), .LAT_BQ(7),
        .CAP_DEPTH(256), .WB_ADR_W(22)
    ) dut (
        .aclk(aclk), .reset_i(reset_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .raw_i(raw_i), .lpf_i(lpf_i), .bq_i(bq_i), .trig_i(trig_i),
        .dat_o(dat_o), .cap_done_o(cap_done_o)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc_n <= cyc_n + 1;

    function automatic logic [BW-1:0] ramp_bus(input int v);
        logic [BW-1:0] b;
        b = '0;
        for (int s = 0; s < 8; s++) b[2*96 + s*12 +: 12] = 12'(v);
        return b;
    endfunction

    function automatic logic [31:0] ramp_word(input int v, input int w);
        logic [95:0] e;
        e = {8{12'(v)}};
        if (w == 3) return 32'h0;
        return e[w*32 +: 32];
    endfunction

    // Chain model: LPF and biquad outputs are the raw stream delayed 3 and 7 clocks
    always @(posedge aclk) begin
        for (int i = 6; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = raw_i;
        #2;
        if (ramp_en) begin
            rc = rc + 1;
            raw_i = ramp_bus(rc);
        end else begin
            raw_i = raw_set;
        end
        lpf_i = hist[2];
        bq_i  = hist[6];
    end

    // Scoreboard monitor for WB read data
    always @(negedge aclk) begin
        if (wb_ack_o && !wb_we_i) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_read_ack: got %h, nothing expected", wb_dat_o);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_nm = name_q.pop_front();
                if (wb_dat_o !== mon_e) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", mon_nm, wb_dat_o, mon_e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wb_issue(input logic [21:0] adr, input logic [31:0] dat, input logic we);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
    endtask

    // Also drops trig_i after the accept edge, so trig can be paired with a request
    task automatic wb_wait();
        int n;
        n = 0;
        tick();
        while (!wb_ack_o && n < 8) begin
            tick();
            n++;
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        trig_i   = 1'b0;
        n_chk++;
        if (!wb_ack_o) begin
            n_fail++;
            $display("FAIL wb_ack_timeout: ack %b expected 1", wb_ack_o);
        end
        tick();
        n_chk++;
        if (wb_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wb_ack_width: ack %b expected 0", wb_ack_o);
        end
    endtask

    task automatic wb_write(input logic [21:0] adr, input logic [31:0] dat);
        wb_issue(adr, dat, 1'b1);
        wb_wait();
    endtask

    task automatic wb_read(input logic [21:0] adr, input logic [31:0] exp, input string nm);
        exp_q.push_back(exp);
        name_q.push_back(nm);
        wb_issue(adr, 32'h0, 1'b0);
        wb_wait();
    endtask

    task automatic trig_pulse();
        trig_i = 1'b1;
        #2;
        rc_trig = rc;
        tick();
        trig_i = 1'b0;
    endtask

    initial begin
        imp = '0;
        imp[11:0] = 12'h7FF;
        repeat (3) tick();
        check("rst_dat_o", dat_o, '0);
        check("rst_cap_done", BW'(cap_done_o), '0);
        check("rst_wb_ack", BW'(wb_ack_o), '0);
        check("rst_wb_dat", BW'(wb_dat_o), '0);
        reset_i = 1'b0;
        tick();
        wb_read(22'd3, 32'h0000_AAAA, "rst_tapsel");

        // Impulse alignment through each tap selection of channel 0
        for (int t = 0; t < 4; t++) begin
            wb_write(22'd3, 32'h0000_AAA8 | 32'(t));
            repeat (10) tick();
            raw_set = imp;
            tick();
            raw_set = '0;
            repeat (6) tick();
            check($sformatf("imp_early_t%0d", t), dat_o, '0);
            tick();
            check($sformatf("imp_hit_t%0d", t), dat_o, (t == 3) ? BW'(0) : imp);
            tick();
            check($sformatf("imp_late_t%0d", t), dat_o, '0);
        end
        wb_read(22'd3, 32'h0000_AAAB, "tapsel_readback");

        // Full capture of the raw ramp on channel 2
        ramp_en = 1'b1;
        repeat (10) tick();
        wb_write(22'd2, 32'd2);
        wb_write(22'd4, 32'd0);
        wb_read(22'd2, 32'd2, "capch_readback");
        wb_write(22'd0, 32'd1);
        wb_read(22'd1, 32'h0000_0001, "status_armed");
        trig_pulse();
        repeat (9) tick();
        wb_read(22'd1024, 32'h0, "buf_read_in_capture");
        repeat (290) tick();
        check("cap_done_high", BW'(cap_done_o), BW'(1));
        wb_read(22'd1, 32'h0100_0003, "status_done");
        foreach (exp_q[i]) begin end
        for (int j = 0; j < 4; j++) begin
            int k;
            k = (j == 0) ? 0 : (j == 1) ? 1 : (j == 2) ? 100 : 255;
            for (int w = 0; w < 4; w++)
                wb_read(22'(1024 + k*4 + w), ramp_word(rc_trig - 7 + k, w),
                        $sformatf("entry%0d_word%0d", k, w));
        end

        // Abort at entry 100, then confirm the next capture restarts its count
        wb_write(22'd0, 32'd1);
        check("cap_done_cleared", BW'(cap_done_o), '0);
        wb_read(22'd1, 32'h0100_0001, "status_rearmed");
        trig_pulse();
        repeat (99) tick();
        wb_write(22'd0, 32'd2);
        wb_read(22'd1, 32'h0064_0000, "status_abort100");
        wb_write(22'd0, 32'd1);
        trig_pulse();
        wb_read(22'd1, 32'h0001_0002, "status_restart");
        wb_write(22'd0, 32'd3);
        wb_read(22'd1, 32'h0003_0000, "status_abort_wins");

        // Arm and trigger in the same cycle: trigger must be ignored
        wb_issue(22'd0, 32'd1, 1'b1);
        trig_i = 1'b1;
        wb_wait();
        wb_read(22'd1, 32'h0003_0001, "status_arm_trig_same");
        trig_pulse();
        wb_read(22'd1, 32'h0001_0002, "status_trig_next");

        // Reset at entry 50
        repeat (47) tick();
        reset_i = 1'b1;
        tick();
        check("midrst_dat_o", dat_o, '0);
        check("midrst_cap_done", BW'(cap_done_o), '0);
        check("midrst_wb_ack", BW'(wb_ack_o), '0);
        check("midrst_wb_dat", BW'(wb_dat_o), '0);
        reset_i = 1'b0;
        rel_n = cyc_n;
        wb_read(22'd1, 32'h0, "midrst_status");
        wb_read(22'd2, 32'h0, "midrst_capch");
        wb_read(22'd3, 32'h0000_AAAA, "midrst_tapsel");
        wb_read(22'd4, 32'h0, "midrst_captap");
        wb_read(22'd5, 32'h0, "midrst_tstamp");
        wb_read(22'd7, 32'h0, "unmapped_0x7");
        wb_read(22'd0, 32'h0, "ctrl_reads_zero");
        wb_read(22'd2048, 32'h0, "unmapped_past_buf");

        // Trigger exactly 1000 clocks after reset release
        wb_write(22'd0, 32'd1);
        while (cyc_n - rel_n < 1000) tick();
        trig_pulse();
`ifdef TRIG_CAP_TIMESTAMP_EN
        wb_read(22'd5, 32'd1000, "tstamp");
`else
        wb_read(22'd5, 32'd0, "tstamp");
`endif
        wb_write(22'd0, 32'd2);

        repeat (4) tick();
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d reads pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
